audio_dac_serializer: RTL and testbench

//  Downstream of the synthesizer: takes parallel 16-bit L/R samples and shifts them serially to the DE2 audio CODEC DAC pin.
//  The CODEC is master: AUD_BCLK and AUD_DACLRCK are inputs, synchronised into iCLK_50.

---
 rtl/audio_dac_serializer_if.sv | 21 ++
 rtl/audio_dac_serializer.sv | 91 +++++++++
 tb/tb_audio_dac_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/audio_dac_serializer_if.sv
// audio_dac_serializer_if: CODEC clocks, sample inputs and serial/status outputs of the DAC serializer
interface audio_dac_serializer_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    AUD_BCLK;
  logic                    AUD_DACLRCK;
  logic [SAMPLE_WIDTH-1:0] iSampleL;
  logic [SAMPLE_WIDTH-1:0] iSampleR;
  logic                    iMute;
  logic                    oAUD_DACDAT;
  logic                    oFrameTick;
  logic                    oFrameErr;
  modport slave (
    input  AUD_BCLK, AUD_DACLRCK, iSampleL, iSampleR, iMute,
    output oAUD_DACDAT, oFrameTick, oFrameErr
  );
  modport master (
    output AUD_BCLK, AUD_DACLRCK, iSampleL, iSampleR, iMute,
    input  oAUD_DACDAT, oFrameTick, oFrameErr
  );
endinterface

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: shifts coherently captured L/R samples MSB-first to the CODEC DAC pin, slaved to CODEC BCLK/LRCK
module audio_dac_serializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int I2S_DELAY    = 1
) (
  input logic                   iCLK_50,
  input logic                   Reset,
  audio_dac_serializer_if.slave aud
);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q;
  logic bclk_prev_q, lrck_last_q, lrck_last_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d, sr_q, sr_d;
  logic [SAMPLE_WIDTH-1:0] cap_l, cap_r, load_word;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dac_q, dac_d, tick_q, tick_d, err_q, err_d;
  logic bclk_s, lrck_s, bclk_fall, slot_edge, load, shifting;
  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign bclk_fall = bclk_prev_q & ~bclk_s;
  assign slot_edge = bclk_fall & (lrck_s != lrck_last_q);
  // IDLE only wakes on a left slot so a partial frame is never emitted
  assign load      = slot_edge & ((state_q != IDLE) | ~lrck_s);
  assign shifting  = bclk_fall & (state_q == SHIFT) & (cnt_q != LAST);
  assign cap_l     = aud.iMute ? '0 : aud.iSampleL;
  assign cap_r     = aud.iMute ? '0 : aud.iSampleR;
  assign load_word = lrck_s ? hold_r_q : cap_l;
  always_ff @(posedge iCLK_50) begin
    if (Reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = load ? SHIFT :
              (bclk_fall && state_q == SHIFT && cnt_q == LAST) ? PAD : state_q;
  end
  always_comb begin
    hold_l_d    = (load & ~lrck_s) ? cap_l : hold_l_q;
    hold_r_d    = (load & ~lrck_s) ? cap_r : hold_r_q;
    lrck_last_d = bclk_fall ? lrck_s : lrck_last_q;
    tick_d      = load & ~lrck_s;
    err_d       = slot_edge & (state_q == SHIFT) & (cnt_q != LAST);
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    dac_d       = dac_q;
    if (load) begin
      sr_d  = (I2S_DELAY != 0) ? load_word : {load_word[SAMPLE_WIDTH-2:0], 1'b0};
      cnt_d = (I2S_DELAY != 0) ? '0 : CW'(1);
      dac_d = (I2S_DELAY != 0) ? 1'b0 : load_word[SAMPLE_WIDTH-1];
    end else if (shifting) begin
      sr_d  = {sr_q[SAMPLE_WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
      dac_d = sr_q[SAMPLE_WIDTH-1];
    end else if (bclk_fall) begin
      dac_d = 1'b0;
    end
  end
  always_ff @(posedge iCLK_50) begin
    if (Reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_prev_q <= 1'b0;
      lrck_last_q <= 1'b1;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      dac_q       <= 1'b0;
      tick_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], aud.AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], aud.AUD_DACLRCK};
      bclk_prev_q <= bclk_s;
      lrck_last_q <= lrck_last_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      dac_q       <= dac_d;
      tick_q      <= tick_d;
      err_q       <= err_d;
    end
  end
  assign aud.oAUD_DACDAT = dac_q;
  assign aud.oFrameTick  = tick_q;
  assign aud.oFrameErr   = err_q;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: I2S and left-justified instances fed from one CODEC model, checked by a slot receiver against a queue
module tb_audio_dac_serializer;
  typedef struct {
    logic [31:0] w;
    int          n;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, bclk = 1'b1, lrck = 1'b1, mute = 1'b0;
  logic [15:0] samp_l = '0, samp_r = '0;
  exp_t q0[$], q1[$];
  int n_checks = 0, n_fail = 0;
  int tick0 = 0, tick1 = 0, err0 = 0, err1 = 0, exp_ticks = 0;
  logic mon_lp = 1'b1;
  int mon_nb = 0;
  logic [31:0] mon_s0 = '0, mon_s1 = '0;
  always #5 clk = ~clk;
  audio_dac_serializer_if #(.SAMPLE_WIDTH(16)) if0 ();
  audio_dac_serializer_if #(.SAMPLE_WIDTH(16)) if1 ();
  assign if0.AUD_BCLK = bclk;
  assign if0.AUD_DACLRCK = lrck;
  assign if0.iSampleL = samp_l;
  assign if0.iSampleR = samp_r;
  assign if0.iMute = mute;
  assign if1.AUD_BCLK = bclk;
  assign if1.AUD_DACLRCK = lrck;
  assign if1.iSampleL = samp_l;
  assign if1.iSampleR = samp_r;
  assign if1.iMute = mute;
  audio_dac_serializer #(.SAMPLE_WIDTH(16), .SYNC_STAGES(2), .I2S_DELAY(1)) dut0 (
    .iCLK_50(clk), .Reset(rst), .aud(if0));
  audio_dac_serializer #(.SAMPLE_WIDTH(16), .SYNC_STAGES(2), .I2S_DELAY(0)) dut1 (
    .iCLK_50(clk), .Reset(rst), .aud(if1));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic check_slot(input int d, input logic [31:0] got, input int n);
    exp_t e;
    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL slot dut%0d: got %h (%0d bits) expected no slot", d, got, n);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk($sformatf("slot_len dut%0d", d), n, e.n);
    chk($sformatf("slot_data dut%0d", d), got, e.w >> (32 - e.n));
  endtask
  task automatic exp_slot(input logic [15:0] s, input int n, input int keep);
    logic [31:0] m, w0, w1;
    m = '1;
    m = (keep >= 32) ? m : ~(m >> keep);
    w0 = {1'b0, s, 15'b0} & m;
    w1 = {s, 16'b0} & m;
    q0.push_back('{w0, n});
    q1.push_back('{w1, n});
  endtask
  task automatic run_bclk(input int n);
    repeat (n) begin
      bclk = 1'b0;
      repeat (8) @(negedge clk);
      bclk = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask
  task automatic frame(input logic [15:0] l, input logic [15:0] r, input logic m, input int nr);
    samp_l = l;
    samp_r = r;
    mute = m;
    exp_slot(m ? 16'h0 : l, 32, 32);
    exp_slot(m ? 16'h0 : r, nr, 32);
    exp_ticks++;
    lrck = 1'b0;
    run_bclk(32);
    lrck = 1'b1;
    run_bclk(nr);
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_dac0"}, 32'(if0.oAUD_DACDAT), 32'd0);
    chk({tag, "_tick0"}, 32'(if0.oFrameTick), 32'd0);
    chk({tag, "_err0"}, 32'(if0.oFrameErr), 32'd0);
    chk({tag, "_dac1"}, 32'(if1.oAUD_DACDAT), 32'd0);
    chk({tag, "_tick1"}, 32'(if1.oFrameTick), 32'd0);
    chk({tag, "_err1"}, 32'(if1.oFrameErr), 32'd0);
  endtask
  // receiver: bits are taken on rising BCLK, a slot closes when LRCK differs at the next rise
  initial begin
    forever begin
      @(posedge bclk);
      if (lrck != mon_lp) begin
        if (mon_nb > 0) begin
          check_slot(0, mon_s0, mon_nb);
          check_slot(1, mon_s1, mon_nb);
        end
        mon_nb = 0;
        mon_s0 = '0;
        mon_s1 = '0;
      end
      mon_lp = lrck;
      mon_s0 = {mon_s0[30:0], if0.oAUD_DACDAT};
      mon_s1 = {mon_s1[30:0], if1.oAUD_DACDAT};
      mon_nb++;
    end
  end
  always @(negedge clk) begin
    if (if0.oFrameTick) tick0++;
    if (if1.oFrameTick) tick1++;
    if (if0.oFrameErr) err0++;
    if (if1.oFrameErr) err1++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    exp_slot(16'h0, 32, 32);
    run_bclk(32);
    frame(16'hA5C3, 16'h0F01, 1'b0, 32);
    samp_l = 16'h1357;
    samp_r = 16'h9BDF;
    exp_slot(16'h1357, 32, 32);
    exp_slot(16'h9BDF, 32, 8);
    exp_ticks++;
    lrck = 1'b0;
    run_bclk(32);
    lrck = 1'b1;
    run_bclk(8);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("midreset");
    rst = 1'b0;
    run_bclk(24);
    frame(16'h2468, 16'hACE0, 1'b0, 32);
    frame(16'hCAFE, 16'hBEEF, 1'b0, 10);
    frame(16'h3C5A, 16'hF00F, 1'b0, 32);
    frame(16'h7FFF, 16'h1234, 1'b1, 32);
    frame(16'h7FFF, 16'h1234, 1'b0, 32);
    frame(16'h8001, 16'h4002, 1'b0, 32);
    samp_l = 16'h6DB6;
    samp_r = 16'h5555;
    exp_slot(16'h6DB6, 32, 32);
    exp_slot(16'h5555, 32, 32);
    exp_ticks++;
    lrck = 1'b0;
    run_bclk(4);
    samp_r = 16'hAAAA;
    run_bclk(28);
    lrck = 1'b1;
    run_bclk(32);
    lrck = 1'b0;
    exp_ticks++;
    run_bclk(2);
    repeat (4) @(negedge clk);
    chk("ticks dut0", tick0, exp_ticks);
    chk("ticks dut1", tick1, exp_ticks);
    chk("errs dut0", err0, 1);
    chk("errs dut1", err1, 1);
    chk("leftover dut0", q0.size(), 0);
    chk("leftover dut1", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
